dl_arb_mux: RTL



---
 rtl/dl_pkg.sv | 22 ++
 rtl/dl_rr_arbiter.sv | 45 ++++
 rtl/dl_arb_mux.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
// ============================================================================
// Module  : dl_pkg
// Brief   : Shared types for the arbitrating mux (arbiter mode, lock states).
// Revision: 1.0
// ============================================================================
`default_nettype none

package dl_pkg;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

endpackage

`default_nettype wire

// File: rtl/dl_rr_arbiter.sv
// ============================================================================
// Module  : dl_rr_arbiter
// Brief   : Combinational rotating-priority arbiter with a fixed-priority mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dl_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               fixed_pri,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0]     w_shift;
    logic [2*NUM_REQ-1:0] w_dbl_req;
    logic [NUM_REQ-1:0]   w_rot_req;
    logic [NUM_REQ-1:0]   w_rot_grant;
    logic [2*NUM_REQ-1:0] w_dbl_grant;
    logic                 w_found;

    // Rotate so the pointer position sits at bit 0, pick the lowest set bit,
    // then rotate the one-hot result back into channel order.
    always_comb begin
        w_shift     = fixed_pri ? '0 : ptr;
        w_dbl_req   = {req, req} >> w_shift;
        w_rot_req   = w_dbl_req[NUM_REQ-1:0];
        w_rot_grant = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_rot_req[i] && !w_found) begin
                w_rot_grant[i] = 1'b1;
                w_found        = 1'b1;
            end
        end
        w_dbl_grant = {w_rot_grant, w_rot_grant} << w_shift;
        grant       = w_dbl_grant[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

`default_nettype wire

// File: rtl/dl_arb_mux.sv
// ============================================================================
// Module  : dl_arb_mux
// Brief   : N-input arbitrating mux with valid/ready, packet lock, output reg.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dl_arb_mux
    import dl_pkg::*;
#(
    parameter int        NUM_BITS     = 32,
    parameter int        NUM_INPUTS   = 4,
    parameter arb_mode_e ARB_MODE     = ARB_RR,
    parameter bit        LOCK_ON_LAST = 1'b0,
    localparam int       SEL_W        = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_INPUTS-1:0]          in_valid,
    input  logic [NUM_INPUTS*NUM_BITS-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]          in_last,
    output logic [NUM_INPUTS-1:0]          in_ready,
    output logic                           out_valid,
    output logic [NUM_BITS-1:0]            out_data,
    output logic                           out_last,
    output logic [SEL_W-1:0]               out_sel,
    input  logic                           out_ready
);

    logic [SEL_W-1:0]      r_ptr;
    logic [SEL_W-1:0]      r_lock_idx;
    lock_state_e           r_lock_state;
    logic                  r_out_valid;
    logic [NUM_BITS-1:0]   r_out_data;
    logic                  r_out_last;
    logic [SEL_W-1:0]      r_out_sel;

    logic [NUM_INPUTS-1:0] w_arb_grant;
    logic [NUM_INPUTS-1:0] w_lock_onehot;
    logic [NUM_INPUTS-1:0] w_grant;
    logic [SEL_W-1:0]      w_grant_idx;
    logic [SEL_W-1:0]      w_ptr_next;
    logic [NUM_BITS-1:0]   w_sel_data;
    logic                  w_sel_last;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_ending;

    dl_rr_arbiter #(
        .NUM_REQ   (NUM_INPUTS)
    ) u_arbiter (
        .req       (in_valid),
        .ptr       (r_ptr),
        .fixed_pri (ARB_MODE == ARB_FIXED),
        .grant     (w_arb_grant)
    );

    always_comb begin
        w_load                    = !r_out_valid || out_ready;
        w_lock_onehot             = '0;
        w_lock_onehot[r_lock_idx] = 1'b1;
        // A held lock owns the grant even when its channel is idle.
        w_grant  = (r_lock_state == ST_LOCKED) ? w_lock_onehot : w_arb_grant;
        in_ready = w_grant & {NUM_INPUTS{w_load && rst_n}};
        w_accept = |(in_valid & in_ready);

        w_grant_idx = '0;
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = SEL_W'(i);
            end
            w_sel_data = w_sel_data | (in_data[i*NUM_BITS +: NUM_BITS] & {NUM_BITS{w_grant[i]}});
            w_sel_last = w_sel_last | (in_last[i] & w_grant[i]);
        end

        w_ending   = !LOCK_ON_LAST || w_sel_last;
        w_ptr_next = (w_grant_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : w_grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_lock_idx   <= '0;
            r_lock_state <= ST_UNLOCKED;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_sel    <= '0;
        end else begin
            if (w_load) begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out_data <= w_sel_data;
                    r_out_last <= w_sel_last;
                    r_out_sel  <= w_grant_idx;
                end
            end
            if (w_accept) begin
                if ((ARB_MODE == ARB_RR) && w_ending) begin
                    r_ptr <= w_ptr_next;
                end
                if (LOCK_ON_LAST) begin
                    case (r_lock_state)
                        ST_UNLOCKED: begin
                            if (!w_sel_last) begin
                                r_lock_state <= ST_LOCKED;
                                r_lock_idx   <= w_grant_idx;
                            end
                        end
                        ST_LOCKED: begin
                            if (w_sel_last) begin
                                r_lock_state <= ST_UNLOCKED;
                            end
                        end
                        default: r_lock_state <= ST_UNLOCKED;
                    endcase
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire
